// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among up to 9 requesters.
// Runs one transaction at a time: IDLE picks a requester, BUSY waits for mem_resp, DONE pulses the response.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 9,
  parameter int unsigned DATA_W  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8:0]        req_read,
  input  logic [8:0]        req_write,
  input  logic              mem_resp,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        sel,
  output logic              mem_read,
  output logic              mem_write,
  output logic [8:0]        req_resp,
  output logic [DATA_W-1:0] req_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [8:0] REQ_MASK = 9'((1 << NUM_REQ) - 1);

  state_t     state, state_nxt;
  logic       op_write;
  logic [3:0] rr_ptr;
  logic [8:0] pending;
  logic       found;
  logic [3:0] pick;
  logic [4:0] scan_idx;

  assign pending = (req_read | req_write) & REQ_MASK;

  // rr_ptr < NUM_REQ, so one conditional subtraction wraps the scan index.
  always_comb begin
    found    = 1'b0;
    pick     = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr} + 5'(k);
      if (scan_idx >= 5'(NUM_REQ)) scan_idx = scan_idx - 5'(NUM_REQ);
      if (!found && pending[scan_idx[3:0]]) begin
        found = 1'b1;
        pick  = scan_idx[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= '0;
      op_write  <= 1'b0;
      rr_ptr    <= '0;
      req_rdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (found) begin
          sel      <= pick;
          op_write <= req_write[pick];
        end
        BUSY: if (mem_resp && !op_write) req_rdata <= mem_rdata;
        DONE: rr_ptr <= (sel == 4'(NUM_REQ - 1)) ? '0 : sel + 4'd1;
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state only; no path from req_* to mem_*.
  always_comb begin
    state_nxt = state;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    req_resp  = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (found) state_nxt = BUSY;
      BUSY: begin
        mem_read  = !op_write;
        mem_write = op_write;
        if (mem_resp) state_nxt = DONE;
      end
      DONE: begin
        req_resp  = 9'(1) << sel;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
